// File: rtl/sir_master.sv
// sir_master: single-outstanding SIR bus master.
// Accepts one command at a time, drives the shared SIR select/address/data
// lines, waits for the OR-ed slave acknowledge, returns a one-cycle response,
// then waits for the acknowledge to drop before the next access.
// Optional feature macro: SIR_MASTER_TIMEOUT_EN. When defined, an ACCESS that
// sees no SirDack for TIMEOUT cycles ends with an error response (RspErr=1).
`timescale 1ns/1ps

module sir_master #(
  parameter int unsigned ADDRWIDTH = 8,
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 CmdValid,
  output logic                 CmdReady,
  input  logic                 CmdRead,
  input  logic [ADDRWIDTH-1:0] CmdAddr,
  input  logic [DATAWIDTH-1:0] CmdWdat,
  output logic                 RspValid,
  output logic [DATAWIDTH-1:0] RspRdat,
  output logic                 RspErr,
  output logic                 SirSel,
  output logic                 SirRead,
  output logic [ADDRWIDTH-1:0] SirAddr,
  output logic [DATAWIDTH-1:0] SirWdat,
  input  logic                 SirDack,
  input  logic [DATAWIDTH-1:0] SirRdat
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state;

  // Commands are only taken while no bus access is in flight.
  assign CmdReady = (state == IDLE);

`ifdef SIR_MASTER_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [7:0] toCnt;
  logic       toHit;
  logic       rspErrQ;

  assign toHit  = (toCnt == TimeoutLast);
  assign RspErr = rspErrQ;
`else
  assign RspErr = 1'b0;
`endif

  // Bus FSM: accept, access until acknowledge (or timeout), release until
  // the acknowledge drops so every slave sees a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      SirSel   <= 1'b0;
      SirRead  <= 1'b0;
      SirAddr  <= '0;
      SirWdat  <= '0;
      RspValid <= 1'b0;
      RspRdat  <= '0;
`ifdef SIR_MASTER_TIMEOUT_EN
      rspErrQ  <= 1'b0;
      toCnt    <= '0;
`endif
    end else begin
      RspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (CmdValid) begin
            SirRead <= CmdRead;
            SirAddr <= CmdAddr;
            SirWdat <= CmdWdat;
            SirSel  <= 1'b1;
            state   <= ACCESS;
`ifdef SIR_MASTER_TIMEOUT_EN
            toCnt   <= '0;
`endif
          end
        end
        ACCESS: begin
          // An acknowledge on the timeout edge still wins over the error.
          if (SirDack) begin
            RspRdat  <= SirRead ? SirRdat : '0;
            RspValid <= 1'b1;
            SirSel   <= 1'b0;
            state    <= RELEASE;
`ifdef SIR_MASTER_TIMEOUT_EN
            rspErrQ  <= 1'b0;
          end else if (toHit) begin
            RspRdat  <= '0;
            RspValid <= 1'b1;
            rspErrQ  <= 1'b1;
            SirSel   <= 1'b0;
            state    <= RELEASE;
          end else begin
            toCnt    <= toCnt + 8'd1;
`endif
          end
        end
        RELEASE: begin
          if (!SirDack) begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          SirSel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sir_master.sv
// tb_sir_master: self-checking bench for sir_master with a registered-ack
// slave (addresses 0x01..0x0F mapped), a vector table, hand-written corner
// sequences and a randomized phase checked against a memory reference model.
`timescale 1ns/1ps

module tb_sir_master;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          CmdValid;
  logic          CmdReady;
  logic          CmdRead;
  logic [AW-1:0] CmdAddr;
  logic [DW-1:0] CmdWdat;
  logic          RspValid;
  logic [DW-1:0] RspRdat;
  logic          RspErr;
  logic          SirSel;
  logic          SirRead;
  logic [AW-1:0] SirAddr;
  logic [DW-1:0] SirWdat;
  logic          SirDack;
  logic [DW-1:0] SirRdat;

  always #5 clk = ~clk;

  sir_master #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdRead(CmdRead),
    .CmdAddr(CmdAddr), .CmdWdat(CmdWdat),
    .RspValid(RspValid), .RspRdat(RspRdat), .RspErr(RspErr),
    .SirSel(SirSel), .SirRead(SirRead), .SirAddr(SirAddr), .SirWdat(SirWdat),
    .SirDack(SirDack), .SirRdat(SirRdat)
  );

  function automatic bit isMapped(input logic [AW-1:0] a);
    return (a >= 8'h01) && (a <= 8'h0F);
  endfunction

  // Registered-ack slave bank: ack and read data one edge after select.
  bit [DW-1:0] slaveMem [256];
  bit          sDack;
  bit [DW-1:0] sRdat;
  always @(posedge clk) begin
    sDack <= SirSel && isMapped(SirAddr);
    sRdat <= (SirSel && isMapped(SirAddr) && SirRead) ? slaveMem[SirAddr] : '0;
    if (SirSel && isMapped(SirAddr) && !SirRead) slaveMem[SirAddr] <= SirWdat;
  end
  assign SirDack = sDack;
  assign SirRdat = sRdat;

  // Reference model: register contents as seen through the master.
  bit [DW-1:0] refMem [256];

  int unsigned nChecks = 0;
  int unsigned nPass   = 0;

  typedef struct {
    bit          rd;
    logic [7:0]  addr;
    logic [31:0] wdat;
    logic [31:0] expRdat;
    bit          expErr;
    int unsigned expLat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Protocol monitor: single-cycle responses and >=2 select-low cycles.
  task automatic monitor();
    bit prevRsp = 1'b0;
    bit prevSel = 1'b0;
    int unsigned lowRun = 100;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevRsp = 1'b0;
        prevSel = 1'b0;
        lowRun  = 100;
      end else begin
        if (RspValid) chk("rsp_single_cycle", 32'(prevRsp), 32'd0);
        if (SirSel && !prevSel) chk("sel_low_gap_ge2", 32'(lowRun >= 2), 32'd1);
        lowRun  = SirSel ? 0 : lowRun + 1;
        prevRsp = RspValid;
        prevSel = SirSel;
      end
    end
  endtask

  // Returns at the acceptance edge (before the DUT update settles).
  task automatic waitAccept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (CmdReady) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called #1 after the acceptance edge; lat counts edges to the response.
  task automatic waitRsp(input int unsigned limit, output bit got, output int unsigned lat,
                         output int unsigned selHigh, output logic [31:0] rdat,
                         output logic err, output logic selAtRsp, output logic rdyAtRsp);
    got = 1'b0; lat = 0; selHigh = 0; rdat = '0; err = 1'b0; selAtRsp = 1'b0; rdyAtRsp = 1'b0;
    while (lat < limit) begin
      if (SirSel) selHigh++;
      @(posedge clk); #1;
      lat++;
      if (RspValid) begin
        got = 1'b1; rdat = RspRdat; err = RspErr; selAtRsp = SirSel; rdyAtRsp = CmdReady;
        break;
      end
    end
  endtask

  task automatic waitIdle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (CmdReady) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_back_to_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic doCmd(input string tag, input bit rd, input logic [7:0] addr,
                       input logic [31:0] wdat, input logic [31:0] expRdat,
                       input bit expErr, input int unsigned expLat);
    bit ok, got;
    int unsigned lat, selHigh;
    logic [31:0] rdat;
    logic err, selAtRsp, rdyAtRsp;
    CmdRead = rd; CmdAddr = addr; CmdWdat = wdat; CmdValid = 1'b1;
    waitAccept(ok);
    chk({tag, "_accepted"}, 32'(ok), 32'd1);
    #1; CmdValid = 1'b0;
    if (!ok) return;
    chk({tag, "_bus_addr"}, 32'(SirAddr), 32'(addr));
    chk({tag, "_bus_wdat"}, SirWdat, wdat);
    chk({tag, "_bus_read"}, 32'(SirRead), 32'(rd));
    waitRsp(expLat + 4, got, lat, selHigh, rdat, err, selAtRsp, rdyAtRsp);
    chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_rsp_latency"}, lat, expLat);
      chk({tag, "_rsp_rdat"}, rdat, expRdat);
      chk({tag, "_rsp_err"}, 32'(err), 32'(expErr));
      chk({tag, "_sel_high_cycles"}, selHigh, expLat);
      chk({tag, "_sel_low_at_rsp"}, 32'(selAtRsp), 32'd0);
      chk({tag, "_not_ready_at_rsp"}, 32'(rdyAtRsp), 32'd0);
    end
    waitIdle(tag);
    chk({tag, "_addr_held"}, 32'(SirAddr), 32'(addr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1);
  end

  initial begin
    bit ok, got, r;
    int unsigned k, lat, selHigh;
    logic [31:0] rdat;
    logic err, selAtRsp, rdyAtRsp;

    rst = 1'b1; CmdValid = 1'b0; CmdRead = 1'b0; CmdAddr = '0; CmdWdat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_SirSel", 32'(SirSel), 32'd0);
    chk("reset_SirRead", 32'(SirRead), 32'd0);
    chk("reset_SirAddr", 32'(SirAddr), 32'd0);
    chk("reset_SirWdat", SirWdat, 32'd0);
    chk("reset_RspValid", 32'(RspValid), 32'd0);
    chk("reset_RspRdat", RspRdat, 32'd0);
    chk("reset_RspErr", 32'(RspErr), 32'd0);
    chk("reset_CmdReady", 32'(CmdReady), 32'd1);
    rst = 1'b0;
    fork monitor(); join_none

    // Directed vector table
    vecs.push_back('{1'b0, 8'h01, 32'hA5A5A5A5, 32'h0,        1'b0, 2});
    vecs.push_back('{1'b1, 8'h01, 32'h0,        32'hA5A5A5A5, 1'b0, 2});
    vecs.push_back('{1'b0, 8'h02, 32'h12345678, 32'h0,        1'b0, 2});
    vecs.push_back('{1'b1, 8'h02, 32'h0,        32'h12345678, 1'b0, 2});
    vecs.push_back('{1'b1, 8'h03, 32'hFFFFFFFF, 32'h0,        1'b0, 2});
    vecs.push_back('{1'b0, 8'h01, 32'hFFFFFFFF, 32'h0,        1'b0, 2});
    vecs.push_back('{1'b1, 8'h01, 32'h0,        32'hFFFFFFFF, 1'b0, 2});
    vecs.push_back('{1'b0, 8'h0F, 32'h00000001, 32'h0,        1'b0, 2});
    vecs.push_back('{1'b1, 8'h0F, 32'h0,        32'h00000001, 1'b0, 2});
`ifdef SIR_MASTER_TIMEOUT_EN
    vecs.push_back('{1'b1, 8'h7F, 32'h0,        32'h0,        1'b1, TO});
    vecs.push_back('{1'b0, 8'h7F, 32'hCAFEF00D, 32'h0,        1'b1, TO});
    vecs.push_back('{1'b1, 8'h02, 32'h0,        32'h12345678, 1'b0, 2});
`endif
    foreach (vecs[i]) begin
      doCmd($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].wdat,
            vecs[i].expRdat, vecs[i].expErr, vecs[i].expLat);
      if (!vecs[i].rd && isMapped(vecs[i].addr)) begin
        refMem[vecs[i].addr] = vecs[i].wdat;
        chk($sformatf("vec%0d_slave_q", i), slaveMem[vecs[i].addr], vecs[i].wdat);
      end
    end

    // Reset one cycle after acceptance of a read: aborted, no response.
    CmdRead = 1'b1; CmdAddr = 8'h01; CmdWdat = 32'hDEADBEEF; CmdValid = 1'b1;
    waitAccept(ok);
    chk("rstmid_accepted", 32'(ok), 32'd1);
    #1; CmdValid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_SirSel", 32'(SirSel), 32'd0);
    chk("rstmid_RspValid", 32'(RspValid), 32'd0);
    chk("rstmid_SirAddr", 32'(SirAddr), 32'd0);
    chk("rstmid_SirWdat", SirWdat, 32'd0);
    chk("rstmid_SirRead", 32'(SirRead), 32'd0);
    chk("rstmid_RspRdat", RspRdat, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rstmid_no_rsp_%0d", i), 32'(RspValid), 32'd0);
      chk($sformatf("rstmid_ready_%0d", i), 32'(CmdReady), 32'd1);
      chk($sformatf("rstmid_sel_low_%0d", i), 32'(SirSel), 32'd0);
    end

    // Back-to-back writes with CmdValid held high.
    CmdRead = 1'b0; CmdAddr = 8'h01; CmdWdat = 32'h11; CmdValid = 1'b1;
    waitAccept(ok);
    chk("b2b_first_accepted", 32'(ok), 32'd1);
    #1; CmdWdat = 32'h22;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk); r = CmdReady;
      @(posedge clk);
      if (r) begin k = i; break; end
    end
    chk("b2b_second_accept_edge", k, 32'd5);
    #1; CmdValid = 1'b0;
    chk("b2b_first_write_q", slaveMem[1], 32'h11);
    waitRsp(10, got, lat, selHigh, rdat, err, selAtRsp, rdyAtRsp);
    chk("b2b_second_rsp_seen", 32'(got), 32'd1);
    chk("b2b_second_latency", lat, 32'd2);
    waitIdle("b2b");
    chk("b2b_final_q", slaveMem[1], 32'h22);
    refMem[1] = 32'h22;

`ifndef SIR_MASTER_TIMEOUT_EN
    // Without timeout, an unmapped access waits forever.
    CmdRead = 1'b1; CmdAddr = 8'h7F; CmdValid = 1'b1;
    waitAccept(ok);
    chk("noto_accepted", 32'(ok), 32'd1);
    #1; CmdValid = 1'b0;
    waitRsp(1000, got, lat, selHigh, rdat, err, selAtRsp, rdyAtRsp);
    chk("noto_no_rsp", 32'(got), 32'd0);
    chk("noto_sel_held", selHigh, 32'd1000);
    chk("noto_sel_still_high", 32'(SirSel), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("noto_abort_sel_low", 32'(SirSel), 32'd0);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
`endif

    // Randomized commands against the reference memory.
    for (int i = 0; i < 60; i++) begin
      bit rd;
      logic [7:0] a;
      logic [31:0] wd, expR;
      bit expE;
      int unsigned expL;
      rd = 1'(($urandom % 2));
      a  = 8'(1 + ($urandom % 6));
`ifdef SIR_MASTER_TIMEOUT_EN
      if (($urandom % 8) == 0) a = 8'(8'h40 + ($urandom % 64));
`endif
      wd = $urandom;
      if (isMapped(a)) begin
        expR = rd ? refMem[a] : 32'h0;
        expE = 1'b0;
        expL = 2;
      end else begin
        expR = 32'h0;
        expE = 1'b1;
        expL = TO;
      end
      doCmd($sformatf("rnd%0d", i), rd, a, wd, expR, expE, expL);
      if (!rd && isMapped(a)) refMem[a] = wd;
      repeat ($urandom % 3) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
